// File: rtl/sdram_tb_pkg.sv
// Shared definitions for the SDRAM traffic checker.
//   state_t        : run-sequencing states of the checker
//   PAT_*          : PATTERN_MODE encodings understood by sdram_pattern_gen
//   IDX_WIDTH      : word index width, wide enough to hold NUM_WORDS up to 2^16
//   ERR_CNT_WIDTH  : width of the saturating mismatch counter
//   cnt_width()    : width of a counter that must reach a given terminal value
package sdram_tb_pkg;

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WR_REQ    = 3'd2,
    ST_WR_WAIT   = 3'd3,
    ST_RD_REQ    = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam int PAT_FIXED = 0;
  localparam int PAT_INCR  = 1;
  localparam int PAT_WALK  = 2;

  localparam int IDX_WIDTH     = 17;
  localparam int ERR_CNT_WIDTH = 16;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = 16'hFFFF;

  // The +2 keeps the width non-zero when max_val is 0 and leaves headroom
  // for the value itself.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 2);
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational test-pattern source.
//   index   in  IDX_WIDTH   word index i within the run
//   pattern out DATA_WIDTH  data word for index i
// PATTERN_MODE 0 returns SEED, 1 returns SEED+i, 2 returns a walking one
// at bit (i mod DATA_WIDTH). SEED is truncated or zero-extended to
// DATA_WIDTH.
module sdram_pattern_gen
  import sdram_tb_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          PATTERN_MODE = PAT_INCR,
  parameter logic [31:0] SEED         = 32'hCCF0F0F1
) (
  input  logic [IDX_WIDTH-1:0]  index,
  output logic [DATA_WIDTH-1:0] pattern
);

  // Concatenating zeros above SEED lets one slice handle both truncation
  // and zero-extension regardless of DATA_WIDTH.
  localparam logic [DATA_WIDTH+31:0] SEED_WIDE = {{DATA_WIDTH{1'b0}}, SEED};
  localparam logic [DATA_WIDTH-1:0]  SEED_W    = SEED_WIDE[DATA_WIDTH-1:0];
  localparam logic [IDX_WIDTH-1:0]   DW_IDX    = IDX_WIDTH'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0]  ONE_W     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] incr_pat;
  logic [DATA_WIDTH-1:0] walk_pat;
  logic [IDX_WIDTH-1:0]  walk_pos;

  // All three candidates are always computed so the index is used in
  // every mode; the constant mode select reduces to a single path.
  always_comb begin
    walk_pos = index % DW_IDX;
    incr_pat = SEED_W + DATA_WIDTH'(index);
    walk_pat = ONE_W << walk_pos;
    case (PATTERN_MODE)
      PAT_FIXED: pattern = SEED_W;
      PAT_WALK:  pattern = walk_pat;
      default:   pattern = incr_pat;
    endcase
  end

endmodule

// File: rtl/sdram_traffic_checker.sv
// Multi-word write/read-back traffic generator and checker for the SoC side
// of sdram_controller.
//   clk, reset_port            : clock, synchronous active-high reset
//   start_port                 : level, starts a run from IDLE or DONE
//   active_port / done_port    : run in progress / run finished (held)
//   pass_port, timeout_port    : result flags, valid with done
//   error_count_port           : saturating count of mismatching words
//   first_err_addr_port        : word address of the first mismatch
//   soc_side_*                 : registered request interface to the controller
module sdram_traffic_checker
  import sdram_tb_pkg::*;
#(
  parameter int          ADDR_WIDTH       = 23,
  parameter int          DATA_WIDTH       = 32,
  parameter int          NUM_WORDS        = 16,
  parameter int          START_ADDR       = 8086,
  parameter int          ADDR_STRIDE      = 1,
  parameter int          PATTERN_MODE     = PAT_INCR,
  parameter logic [31:0] SEED             = 32'hCCF0F0F1,
  parameter int          INIT_WAIT_CYCLES = 32000,
  parameter int          TIMEOUT_CYCLES   = 1024
) (
  input  logic                      clk,
  input  logic                      reset_port,
  input  logic                      start_port,
  output logic                      active_port,
  output logic                      done_port,
  output logic                      pass_port,
  output logic                      timeout_port,
  output logic [ERR_CNT_WIDTH-1:0]  error_count_port,
  output logic [ADDR_WIDTH-1:0]     first_err_addr_port,
  output logic [ADDR_WIDTH-1:0]     soc_side_addr_port,
  output logic [DATA_WIDTH-1:0]     soc_side_wr_data_port,
  output logic [DATA_WIDTH/8-1:0]   soc_side_wr_mask_port,
  output logic                      soc_side_wr_en_port,
  output logic                      soc_side_rd_en_port,
  input  logic [DATA_WIDTH-1:0]     soc_side_rd_data_port,
  input  logic                      soc_side_busy_port,
  input  logic                      soc_side_ready_port
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int INIT_W = cnt_width(INIT_WAIT_CYCLES);
  localparam int TO_W   = cnt_width(TIMEOUT_CYCLES);

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [INIT_W-1:0]     INIT_LAST =
    INIT_W'((INIT_WAIT_CYCLES > 0) ? INIT_WAIT_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]       TO_LAST   =
    TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                   state_q, state_d;
  logic [IDX_WIDTH-1:0]     idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]    cur_addr_q, cur_addr_d;
  logic [INIT_W-1:0]        init_cnt_q, init_cnt_d;
  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic                     active_q, active_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic                     timeout_q, timeout_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]    first_err_q, first_err_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [MASK_W-1:0]        wr_mask_q, wr_mask_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0]    pat_q, pat_d;

  logic [DATA_WIDTH-1:0]    pattern_cur;
  logic [ERR_CNT_WIDTH-1:0] err_next;
  logic                     expire;
  logic                     go_timeout;
  logic                     mismatch;

  // The generator is indexed by the next index so that the write data
  // register and the compare register (pat_q, which always equals
  // pattern(idx_q)) are both loaded from this single instance.
  sdram_pattern_gen #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PATTERN_MODE (PATTERN_MODE),
    .SEED         (SEED)
  ) u_pattern_gen (
    .index   (idx_d),
    .pattern (pattern_cur)
  );

  assign expire   = (to_cnt_q == TO_LAST);
  assign mismatch = (soc_side_rd_data_port != pat_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_addr_d  = cur_addr_q;
    init_cnt_d  = init_cnt_q;
    to_cnt_d    = to_cnt_q;
    active_d    = active_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_next    = err_cnt_q;
    go_timeout  = 1'b0;

    case (state_q)
      ST_INIT_WAIT: begin
        if (init_cnt_q >= INIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end

      ST_IDLE, ST_DONE: begin
        if (start_port) begin
          state_d     = ST_WR_REQ;
          idx_d       = '0;
          cur_addr_d  = BASE_ADDR;
          to_cnt_d    = '0;
          active_d    = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
        end
      end

      ST_WR_REQ: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (expire) begin
          go_timeout = 1'b1;
        end else if (!soc_side_busy_port) begin
          state_d = ST_WR_WAIT;
        end
      end

      ST_WR_WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (soc_side_ready_port) begin
          to_cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d      = '0;
            cur_addr_d = BASE_ADDR;
            state_d    = ST_RD_REQ;
          end else begin
            idx_d      = idx_q + IDX_WIDTH'(1);
            cur_addr_d = cur_addr_q + STRIDE;
            state_d    = ST_WR_REQ;
          end
        end else if (expire) begin
          go_timeout = 1'b1;
        end
      end

      ST_RD_REQ: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (expire) begin
          go_timeout = 1'b1;
        end else if (!soc_side_busy_port) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (soc_side_ready_port) begin
          to_cnt_d = '0;
          if (mismatch) begin
            if (err_cnt_q != ERR_CNT_MAX) begin
              err_next = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
            if (err_cnt_q == '0) begin
              first_err_d = cur_addr_q;
            end
          end
          err_cnt_d = err_next;
          if (idx_q == LAST_IDX) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            active_d = 1'b0;
            pass_d   = (err_next == '0) && !timeout_q;
          end else begin
            idx_d      = idx_q + IDX_WIDTH'(1);
            cur_addr_d = cur_addr_q + STRIDE;
            state_d    = ST_RD_REQ;
          end
        end else if (expire) begin
          go_timeout = 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT_WAIT;
      end
    endcase

    if (go_timeout) begin
      state_d   = ST_DONE;
      timeout_d = 1'b1;
      done_d    = 1'b1;
      active_d  = 1'b0;
      pass_d    = 1'b0;
    end
  end

  // Request outputs are decoded from the next state so that they are
  // registered yet line up with the cycle the FSM sits in a REQ state.
  always_comb begin
    pat_d     = pattern_cur;
    wr_en_d   = (state_d == ST_WR_REQ);
    rd_en_d   = (state_d == ST_RD_REQ);
    addr_d    = (wr_en_d || rd_en_d) ? cur_addr_d : '0;
    wr_data_d = wr_en_d ? pattern_cur : '0;
    wr_mask_d = wr_en_d ? '1 : '0;
  end

  always_ff @(posedge clk) begin
    if (reset_port) begin
      state_q     <= ST_INIT_WAIT;
      idx_q       <= '0;
      cur_addr_q  <= '0;
      init_cnt_q  <= '0;
      to_cnt_q    <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_mask_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      pat_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_addr_q  <= cur_addr_d;
      init_cnt_q  <= init_cnt_d;
      to_cnt_q    <= to_cnt_d;
      active_q    <= active_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_mask_q   <= wr_mask_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      pat_q       <= pat_d;
    end
  end

  assign active_port           = active_q;
  assign done_port             = done_q;
  assign pass_port             = pass_q;
  assign timeout_port          = timeout_q;
  assign error_count_port      = err_cnt_q;
  assign first_err_addr_port   = first_err_q;
  assign soc_side_addr_port    = addr_q;
  assign soc_side_wr_data_port = wr_data_q;
  assign soc_side_wr_mask_port = wr_mask_q;
  assign soc_side_wr_en_port   = wr_en_q;
  assign soc_side_rd_en_port   = rd_en_q;

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// Self-checking bench for sdram_traffic_checker. Instance A uses the default
// parameters against a controller model with configurable busy stretching,
// read corruption and a stalled write; instance B checks address wrap and
// the walking-one pattern.
module tb_sdram_traffic_checker;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam logic [DW-1:0] SEED = 32'hCCF0F0F1;

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    int            hold;
    int            c0;
    int            c1;
    bit            stray;
    logic [15:0]   exp_err;
    logic [AW-1:0] exp_first;
    bit            exp_pass;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_port;
  logic          start_a, start_b;

  logic          a_active, a_done, a_pass, a_timeout;
  logic [15:0]   a_err;
  logic [AW-1:0] a_first, a_addr;
  logic [DW-1:0] a_wr_data, a_rd_data;
  logic [3:0]    a_wr_mask;
  logic          a_wr_en, a_rd_en, a_busy, a_ready;

  logic          b_active, b_done, b_pass, b_timeout;
  logic [15:0]   b_err;
  logic [AW-1:0] b_first, b_addr;
  logic [DW-1:0] b_wr_data, b_rd_data;
  logic [3:0]    b_wr_mask;
  logic          b_wr_en, b_rd_en, b_busy, b_ready;

  sdram_traffic_checker dut_a (
    .clk                   (clk),
    .reset_port            (reset_port),
    .start_port            (start_a),
    .active_port           (a_active),
    .done_port             (a_done),
    .pass_port             (a_pass),
    .timeout_port          (a_timeout),
    .error_count_port      (a_err),
    .first_err_addr_port   (a_first),
    .soc_side_addr_port    (a_addr),
    .soc_side_wr_data_port (a_wr_data),
    .soc_side_wr_mask_port (a_wr_mask),
    .soc_side_wr_en_port   (a_wr_en),
    .soc_side_rd_en_port   (a_rd_en),
    .soc_side_rd_data_port (a_rd_data),
    .soc_side_busy_port    (a_busy),
    .soc_side_ready_port   (a_ready)
  );

  sdram_traffic_checker #(
    .START_ADDR       (8388606),
    .NUM_WORDS        (4),
    .PATTERN_MODE     (2),
    .INIT_WAIT_CYCLES (8)
  ) dut_b (
    .clk                   (clk),
    .reset_port            (reset_port),
    .start_port            (start_b),
    .active_port           (b_active),
    .done_port             (b_done),
    .pass_port             (b_pass),
    .timeout_port          (b_timeout),
    .error_count_port      (b_err),
    .first_err_addr_port   (b_first),
    .soc_side_addr_port    (b_addr),
    .soc_side_wr_data_port (b_wr_data),
    .soc_side_wr_mask_port (b_wr_mask),
    .soc_side_wr_en_port   (b_wr_en),
    .soc_side_rd_en_port   (b_rd_en),
    .soc_side_rd_data_port (b_rd_data),
    .soc_side_busy_port    (b_busy),
    .soc_side_ready_port   (b_ready)
  );

  int checks = 0;
  int errors = 0;
  int cycle_count = 0;

  always @(posedge clk) cycle_count++;

  // Controller model A state.
  txn_t          exp_q[$];
  txn_t          e_txn;
  logic [DW-1:0] mem_a [int];
  int            busy_hold = 0;
  int            busy_cnt = 0;
  bit            resp_pending = 1'b0;
  bit            resp_is_wr = 1'b0;
  int            resp_addr = 0;
  bit            req_seen = 1'b0;
  logic [AW-1:0] first_addr;
  logic [DW-1:0] first_data;
  int            corrupt0 = -1;
  int            corrupt1 = -1;
  int            stall_wr_idx = -1;
  int            wr_accepts = 0;
  int            rd_accepts = 0;
  int            stall_req_cycle = -1;
  logic [DW-1:0] rd_tmp;

  initial begin
    a_busy = 1'b0;
    a_ready = 1'b0;
    a_rd_data = '0;
    b_busy = 1'b0;
    b_ready = 1'b0;
    b_rd_data = '0;
  end

  // Model A reacts on the falling edge: it sees the registered requests,
  // decides busy for the next rising edge, and returns ready one cycle
  // after the accepting edge. Every accepted request is scoreboarded.
  always @(negedge clk) begin
    a_ready = 1'b0;
    if (resp_pending) begin
      resp_pending = 1'b0;
      a_ready = 1'b1;
      if (!resp_is_wr) begin
        rd_tmp = mem_a.exists(resp_addr) ? mem_a[resp_addr] : '0;
        if (resp_addr == corrupt0 || resp_addr == corrupt1) rd_tmp[0] = ~rd_tmp[0];
        a_rd_data = rd_tmp;
      end
    end
    if (a_wr_en || a_rd_en) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        first_addr = a_addr;
        first_data = a_wr_data;
        if (a_wr_en && wr_accepts == stall_wr_idx) stall_req_cycle = cycle_count;
      end
      if (busy_cnt < busy_hold) begin
        a_busy = 1'b1;
        busy_cnt++;
      end else begin
        a_busy = 1'b0;
        busy_cnt = 0;
        req_seen = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_txn: got wr=%0d addr=%0h, expected no transaction", a_wr_en, a_addr);
        end else begin
          e_txn = exp_q.pop_front();
          if (e_txn.is_wr != a_wr_en || e_txn.addr != a_addr ||
              (a_wr_en && (e_txn.data != a_wr_data || a_wr_mask != 4'hF))) begin
            errors++;
            $display("[TB] FAIL sb_txn: got wr=%0d addr=%0h data=%0h mask=%0h, expected wr=%0d addr=%0h data=%0h",
                     a_wr_en, a_addr, a_wr_data, a_wr_mask, e_txn.is_wr, e_txn.addr, e_txn.data);
          end
        end
        if (busy_hold > 0) begin
          checks++;
          if (first_addr != a_addr || (a_wr_en && first_data != a_wr_data)) begin
            errors++;
            $display("[TB] FAIL req_stable: got addr=%0h data=%0h, first seen addr=%0h data=%0h",
                     a_addr, a_wr_data, first_addr, first_data);
          end
        end
        if (a_wr_en) begin
          mem_a[int'(a_addr)] = a_wr_data;
          if (wr_accepts != stall_wr_idx) resp_pending = 1'b1;
          resp_is_wr = 1'b1;
          wr_accepts++;
        end else begin
          resp_pending = 1'b1;
          resp_is_wr = 1'b0;
          resp_addr = int'(a_addr);
          rd_accepts++;
        end
      end
    end else begin
      a_busy = 1'b0;
      busy_cnt = 0;
      req_seen = 1'b0;
    end
  end

  // Model B: always ready to accept, logs every accepted request.
  txn_t          b_log[$];
  logic [DW-1:0] mem_b [int];
  bit            b_pending = 1'b0;
  int            b_resp_addr = 0;

  always @(negedge clk) begin
    b_ready = 1'b0;
    if (b_pending) begin
      b_pending = 1'b0;
      b_ready = 1'b1;
      b_rd_data = mem_b.exists(b_resp_addr) ? mem_b[b_resp_addr] : '0;
    end
    if (b_wr_en || b_rd_en) begin
      b_log.push_back('{b_wr_en, b_addr, b_wr_data});
      if (b_wr_en) mem_b[int'(b_addr)] = b_wr_data;
      b_resp_addr = int'(b_addr);
      b_pending = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAllZeroA(input string tag);
    checkOutput({tag, "_active"}, 32'(a_active), 0);
    checkOutput({tag, "_done"}, 32'(a_done), 0);
    checkOutput({tag, "_pass"}, 32'(a_pass), 0);
    checkOutput({tag, "_timeout"}, 32'(a_timeout), 0);
    checkOutput({tag, "_err"}, 32'(a_err), 0);
    checkOutput({tag, "_first"}, 32'(a_first), 0);
    checkOutput({tag, "_addr"}, 32'(a_addr), 0);
    checkOutput({tag, "_wdata"}, a_wr_data, 0);
    checkOutput({tag, "_mask"}, 32'(a_wr_mask), 0);
    checkOutput({tag, "_wr_en"}, 32'(a_wr_en), 0);
    checkOutput({tag, "_rd_en"}, 32'(a_rd_en), 0);
  endtask

  // Configure model A and queue the 16 writes then 16 reads of one run.
  task automatic pushRun(input int hold, input int c0, input int c1, input int stall_idx);
    busy_hold = hold;
    corrupt0 = c0;
    corrupt1 = c1;
    stall_wr_idx = stall_idx;
    wr_accepts = 0;
    rd_accepts = 0;
    stall_req_cycle = -1;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, AW'(8086 + i), SEED + DW'(i)});
    for (int i = 0; i < 16; i++) exp_q.push_back('{1'b0, AW'(8086 + i), '0});
  endtask

  task automatic applyStimulus(input int hold, input int c0, input int c1, input int stall_idx);
    pushRun(hold, c0, c1, stall_idx);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checkOutput("start_active", 32'(a_active), 1);
    checkOutput("start_done_clr", 32'(a_done), 0);
    checkOutput("start_err_clr", 32'(a_err), 0);
    checkOutput("start_first_clr", 32'(a_first), 0);
    checkOutput("start_wr_en", 32'(a_wr_en), 1);
    checkOutput("start_mask", 32'(a_wr_mask), 32'hF);
  endtask

  task automatic waitDoneA(input int limit);
    int n = 0;
    while (!a_done && n < limit) begin
      tick();
      n++;
    end
    checkOutput("done_wait", 32'(a_done), 1);
  endtask

  vec_t vecs[4];
  int   c_r;
  int   n;
  logic [AW-1:0] b_addrs [4];

  initial begin
    vecs[0] = '{0, -1, -1, 1'b1, 16'd0, 23'd0, 1'b1};
    vecs[1] = '{0, 8090, 8095, 1'b0, 16'd2, 23'd8090, 1'b0};
    vecs[2] = '{5, -1, -1, 1'b1, 16'd0, 23'd0, 1'b1};
    vecs[3] = '{2, 8101, -1, 1'b0, 16'd1, 23'd8101, 1'b0};
    b_addrs[0] = 23'h7FFFFE;
    b_addrs[1] = 23'h7FFFFF;
    b_addrs[2] = 23'h000000;
    b_addrs[3] = 23'h000001;

    reset_port = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) tick();
    checkAllZeroA("reset");
    reset_port = 1'b0;
    repeat (32005) tick();
    checkOutput("idle_active", 32'(a_active), 0);

    for (int k = 0; k < 4; k++) begin
      $display("[TB] vector %0d", k);
      if (vecs[k].stray) begin
        a_ready = 1'b1;
        tick();
        checkOutput("stray_active", 32'(a_active), 0);
        checkOutput("stray_wr_en", 32'(a_wr_en), 0);
        checkOutput("stray_done", 32'(a_done), (k > 0) ? 1 : 0);
      end
      applyStimulus(vecs[k].hold, vecs[k].c0, vecs[k].c1, -1);
      waitDoneA(2000);
      repeat (3) tick();
      checkOutput("res_done_hold", 32'(a_done), 1);
      checkOutput("res_active", 32'(a_active), 0);
      checkOutput("res_pass", 32'(a_pass), 32'(vecs[k].exp_pass));
      checkOutput("res_timeout", 32'(a_timeout), 0);
      checkOutput("res_err", 32'(a_err), 32'(vecs[k].exp_err));
      checkOutput("res_first", 32'(a_first), 32'(vecs[k].exp_first));
      checkOutput("res_idle_req", 32'({a_wr_en, a_rd_en}), 0);
      checkOutput("res_sb_empty", 32'(exp_q.size()), 0);
    end

    // Address wrap and walking-one pattern on instance B.
    b_log.delete();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (!b_done && n < 200) begin
      tick();
      n++;
    end
    checkOutput("b_done", 32'(b_done), 1);
    checkOutput("b_pass", 32'(b_pass), 1);
    checkOutput("b_err", 32'(b_err), 0);
    checkOutput("b_txn_count", 32'(b_log.size()), 8);
    for (int i = 0; i < 8 && i < b_log.size(); i++) begin
      checkOutput("b_is_wr", 32'(b_log[i].is_wr), (i < 4) ? 1 : 0);
      checkOutput("b_addr", 32'(b_log[i].addr), 32'(b_addrs[i % 4]));
      if (i < 4) checkOutput("b_wdata", b_log[i].data, 32'd1 << i);
    end

    // Controller stops answering after write index 3.
    applyStimulus(0, -1, -1, 3);
    n = 0;
    while (!a_timeout && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("to_flag", 32'(a_timeout), 1);
    checkOutput("to_latency", 32'(cycle_count - stall_req_cycle), 1024);
    checkOutput("to_done", 32'(a_done), 1);
    checkOutput("to_pass", 32'(a_pass), 0);
    checkOutput("to_wr_en", 32'(a_wr_en), 0);
    checkOutput("to_rd_en", 32'(a_rd_en), 0);
    checkOutput("to_active", 32'(a_active), 0);
    checkOutput("to_wr_accepts", 32'(wr_accepts), 4);
    exp_q.delete();

    // Reset during RD_WAIT, then start held high from mid-INIT_WAIT.
    applyStimulus(0, -1, -1, -1);
    n = 0;
    while (rd_accepts < 1 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("rst_reached_read", 32'(rd_accepts), 1);
    tick();
    checkOutput("rst_in_rd_wait", 32'({a_active, a_rd_en}), 32'b10);
    reset_port = 1'b1;
    tick();
    c_r = cycle_count;
    checkAllZeroA("midrst");
    reset_port = 1'b0;
    exp_q.delete();
    repeat (16000) tick();
    pushRun(0, -1, -1, -1);
    start_a = 1'b1;
    n = 0;
    while (!a_active && n < 20000) begin
      tick();
      n++;
    end
    start_a = 1'b0;
    checkOutput("init_wait_len", 32'(cycle_count - c_r), 32001);
    waitDoneA(2000);
    checkOutput("post_rst_pass", 32'(a_pass), 1);
    checkOutput("post_rst_err", 32'(a_err), 0);
    checkOutput("post_rst_sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
